// File: rtl/mux_arb_n.sv
// N-channel valid/ready selector with a single registered output stage.
// Channels are picked either by an explicit index or by round-robin arbitration.
module mux_arb_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      ctrl,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NI = int'(N);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("mux_arb_n: N must be in 2..16");
    end
    if (SELW != $clog2(N)) begin : g_bad_selw
        $error("mux_arb_n: SELW must equal clog2(N)");
    end

    logic            load_en;
    logic [SELW-1:0] rr_ptr;

    logic            sel_vld;
    logic            rr_vld;
    logic [SELW-1:0] rr_idx;
    int              rr_best;
    int              rr_dist;

    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !out_valid || out_ready;

    // Explicit select; an index at or beyond N never matches a channel.
    always_comb begin
        sel_vld = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if (int'(ctrl) == i && in_valid[i]) begin
                sel_vld = 1'b1;
            end
        end
    end

    // Round-robin: the valid channel closest after rr_ptr (modulo N) wins.
    always_comb begin
        rr_vld  = 1'b0;
        rr_idx  = '0;
        rr_best = NI;
        rr_dist = 0;
        for (int i = 0; i < NI; i++) begin
            rr_dist = i - int'(rr_ptr) - 1;
            if (rr_dist < 0) begin
                rr_dist = rr_dist + NI;
            end
            if (in_valid[i] && rr_dist < rr_best) begin
                rr_best = rr_dist;
                rr_vld  = 1'b1;
                rr_idx  = SELW'(i);
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end else begin
            grant_vld = sel_vld;
            grant_idx = ctrl;
        end
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < NI; i++) begin
            if (int'(grant_idx) == i) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load_en && grant_vld;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SELW'(N - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_src   <= grant_idx;
                // Tracked in both modes so round-robin resumes after explicit picks.
                rr_ptr    <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel, WIDTH-bit selector; successor to the fixed 32-bit 4:1 datapath mux.
- Adds per-channel valid/ready handshakes, a registered output stage with backpressure, and a runtime mode: explicit select, or round-robin arbitration across valid channels.
- Used to merge CPU datapath/bus sources (e.g. write-back or memory-request sources) into one registered stream.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, channel count (2..16, not required to be a power of two).
- SELW, 2, select/source index width; must equal ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- mode  input  1  0 = explicit select via ctrl; 1 = round-robin.
- ctrl  input  SELW  channel index used when mode=0.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i holds a word.
- in_ready  output  N  channel i word is taken this cycle.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SELW  channel index that out_data came from.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1, so channel 0 has first round-robin priority.
- Reset mid-transfer discards the held word; no partial state survives.
- load_en = !out_valid || out_ready (single-entry pipeline register; full throughput under continuous out_ready=1).
- Grant, combinational, at most one hot:
  - mode=0: grant = ctrl if ctrl < N and in_valid[ctrl]; otherwise no grant.
  - mode=1: grant = first i with in_valid[i], scanning rr_ptr+1, rr_ptr+2, ... modulo N (wraps N-1 -> 0); no grant if in_valid is all zero.
- in_ready[i] = load_en && grant==i. in_ready is never asserted for a channel with in_valid=0.
- Transfer: on a clock edge with load_en and a grant:
  - out_data <= selected channel data; out_src <= grant; out_valid <= 1.
  - rr_ptr <= grant. rr_ptr is updated in both modes, so round-robin resumes fairly after explicit-select use.
- No grant and load_en: out_valid <= 0; out_data and out_src hold their previous values.
- !load_en (out_valid=1, out_ready=0): out_data, out_src and out_valid hold; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Simultaneous output drain and input load in the same cycle: both occur, with no bubble.
- Changes to mode or ctrl affect only the current-cycle grant; a held output word is unaffected.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0; each channel is granted exactly once per N transfers.
- ctrl >= N (N not a power of two): treated as idle. No grant, no in_ready, no error.
- Data is passed unmodified. No width conversion; no combinational path from in_data to out_data.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-transfer (out_valid=1).
  - Required: out_valid, out_data, out_src drop to 0 immediately, without a clock edge.
  - After release with in_valid=0: out_valid stays 0 and in_ready=0.
- Explicit select:
  - Stimulus: mode=0, N=4, in_data = {D:0xDDDD0003, C:0xCCCC0002, B:0xBBBB0001, A:0xAAAA0000}, in_valid=4'b1111, out_ready=1, ctrl stepped 0..3.
  - Required: one cycle later, out_data = 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 with out_src = 0..3; in_ready is one-hot matching ctrl.
- Round-robin wrap:
  - Stimulus: mode=1, in_valid=4'b1111, out_ready=1, for 8 cycles.
  - Required: out_src sequence 0,1,2,3,0,1,2,3.
  - Then in_valid=4'b1010: out_src alternates 1,3.
- Backpressure:
  - Stimulus: out_ready=0 while out_valid=1, held 3 cycles.
  - Required: out_data and out_src held, in_ready=0.
  - On out_ready=1: the held word drains and the next grant loads in the same edge, with out_valid staying 1.
- Invalid/idle select:
  - Stimulus: N=3, mode=0, ctrl=3. Then ctrl=1 with in_valid[1]=0.
  - Required in both cases: no in_ready, out_valid falls to 0 after the held word drains.
- Mode switch fairness:
  - Stimulus: mode=0 grants channel 2, then mode=1 with in_valid=4'b1111.
  - Required: next grant is channel 3, then 0.
